// File: rtl/bus_arbiter4.sv
// Four-master memory bus arbiter: master 0 has fixed top priority, masters 1-3 rotate.
// Ownership runs IDLE -> OWN -> one dead TURN cycle, with an ownership timeout.
module bus_arbiter4 #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  logic [1:0]    state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          timeoutErr_q, timeoutErr_d;
  logic [1:0]    rrPtr_q, rrPtr_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [1:0] rrCand1, rrCand2;
  logic       winValid;
  logic [1:0] winIdx;

  // Round-robin successor within masters 1..3 (3 wraps back to 1).
  function automatic logic [1:0] nextRr(input logic [1:0] idx);
    return (idx == 2'd3) ? 2'd1 : idx + 2'd1;
  endfunction

  assign rrCand1 = nextRr(rrPtr_q);
  assign rrCand2 = nextRr(rrCand1);

  always_comb begin
    winValid = 1'b0;
    winIdx   = 2'd0;
    if (req[0]) begin
      winValid = 1'b1;
      winIdx   = 2'd0;
    end else if (req[rrPtr_q]) begin
      winValid = 1'b1;
      winIdx   = rrPtr_q;
    end else if (req[rrCand1]) begin
      winValid = 1'b1;
      winIdx   = rrCand1;
    end else if (req[rrCand2]) begin
      winValid = 1'b1;
      winIdx   = rrCand2;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    timeoutErr_d = 1'b0;
    rrPtr_d      = rrPtr_q;
    timer_d      = timer_q;
    case (state_q)
      IDLE, TURN: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        if (winValid) begin
          state_d = OWN;
          gnt_d   = 4'b0001 << winIdx;
          owner_d = winIdx;
          busy_d  = 1'b1;
          timer_d = '0;
          if (winIdx != 2'd0) begin
            rrPtr_d = nextRr(winIdx);
          end
        end
      end
      OWN: begin
        // done outranks the timeout so a completion on the last allowed cycle is clean.
        if (done && lock[owner_q] && req[owner_q]) begin
          timer_d = '0;
        end else if (done || !req[owner_q]) begin
          state_d = TURN;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          state_d      = TURN;
          gnt_d        = 4'b0000;
          busy_d       = 1'b0;
          timeoutErr_d = 1'b1;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= 4'b0000;
      owner_q      <= 2'd0;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
      rrPtr_q      <= 2'd1;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      timeoutErr_q <= timeoutErr_d;
      rrPtr_q      <= rrPtr_d;
      timer_q      <= timer_d;
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = timeoutErr_q;

endmodule
